pixel_compositor: RTL and testbench
===================================

# pixel_compositor

Final pixel stage between the sprite renderers and the VGA pins. Takes the VGA timing generator's raster position and sync signals plus the registered outputs of the game sprite and end-screen sprite renderers, and composites them into one 12-bit RGB pixel. It resolves layer priority and a transparent colour key, and fades the end screen in over several frames once the game is over. Sync signals are re-aligned to the sprite renderers' one-cycle latency, so RGB and sync leave the block together.

## Interface
- BG_COLOR, 12'h000: background colour as {R,G,B}, 4 bits each.
- KEY_COLOR, 12'hF0F: sprite pixel value treated as transparent.
- FADE_STEP_FRAMES, 4: frames per alpha increment; range 1..255.

- CLK  in  1  pixel clock; one raster position per cycle.
- RST_N  in  1  reset; asynchronous assert, active-low, deassertion synchronous to CLK.
- x  in  10  current pixel x from the timing generator (stage 0).
- y  in  9  current pixel y (stage 0).
- video_on  in  1  active-area flag (stage 0).
- hsync_in, vsync_in  in  1 each  active-low syncs (stage 0).
- game_sprite_data  in  12  game-layer pixel (stage 1, one cycle after x/y).
- game_sprite_enable  in  1  game-layer pixel valid (stage 1).
- end_sprite_data_out  in  12  end-screen pixel (stage 1).
- end_sprite_enable  in  1  end-screen pixel valid (stage 1).
- game_over  in  1  level; high while the end screen is requested.
- vga_r, vga_g, vga_b  out  4 each  registered colour.
- hsync, vsync  out  1 each  registered, aligned syncs.

## Operation
- Stage 0 to stage 1: register video_on, hsync_in and vsync_in once. This matches the sprite renderers' registered outputs.
- Under layer (stage 1): game_sprite_data when game_sprite_enable=1 and the data is not KEY_COLOR; otherwise BG_COLOR.
- End layer is visible when end_sprite_enable=1, the data is not KEY_COLOR and alpha>0.
- Blend per 4-bit channel: out = (e*a + u*(16-a)) >> 4.
  - e is the end-layer channel, u is the under-layer channel, and a is alpha in 0..16.
  - The intermediate is 8 bits wide; the maximum sum is 240, so there is no overflow. The result is truncated, not rounded.
- Where the end layer is not visible, out = u.
- When aligned video_on=0, RGB output is 0.
- Frame tick: one-cycle pulse when stage-0 x==0 and y==0 and the previous cycle was not (x,y)=(0,0).
- Fade FSM, advanced only on frame ticks except where noted:
  - IDLE: a=0, frame counter held at 0. If game_over=1 at a tick, go to FADE.
  - FADE: the frame counter counts ticks. When it reaches FADE_STEP_FRAMES-1 it wraps to 0 and a increments. Entering a=16 moves the FSM to SHOW.
  - SHOW: a=16 held.
  - Any state: game_over=0 forces IDLE, a=0 and counter 0 on the next CLK edge, regardless of tick. If a tick coincides, the deassert wins.
- Because a changes only on ticks (except clear), it is constant across a frame. The only exception is the immediate clear on deassert.

## Timing
- Latency from x/y/video_on/sync at stage 0 to vga_*/hsync/vsync is exactly 2 cycles. Stage-1 sprite inputs reach the outputs 1 cycle later.
- Reset values:
  - vga_r, vga_g, vga_b = 0.
  - hsync = vsync = 1.
  - Internal sync/video_on delay registers = inactive (1/1/0).
  - FSM in IDLE, a=0, frame counter 0, tick history 0.
- Reset mid-frame or mid-fade drops all state immediately. The fade restarts from a=0 at the first tick after release with game_over=1.
- Transitions:
  - FADE entry at tick N gives a=0 for frame N.
  - The first increment happens at tick N+FADE_STEP_FRAMES.
  - SHOW is reached 16*FADE_STEP_FRAMES ticks after entry.
- game_over toggling mid-frame is not acted on until the next tick (rise) or the next edge (fall).

## Structure
- Shared package compositor_pkg holds:
  - the state typedef (IDLE, FADE, SHOW);
  - ALPHA_MAX=16 and the alpha width (5);
  - the channel width (4) and the colour width (12).
- One sub-module, alpha_blend4: combinational single-channel blend (e, u, a → out). It is instantiated three times. All registers live in pixel_compositor.

## Test plan
- Reset: assert RST_N=0 mid-frame with sprites active → outputs 0, hsync=vsync=1 asynchronously. After release, IDLE with a=0.
- Latency: BG_COLOR=12'h123, video_on=1, no sprites; pulse hsync_in low for 1 cycle → RGB 1/2/3 and the hsync low pulse both appear exactly 2 cycles after stage 0.
- Key and priority, game_over=0:
  - game sprite 12'hF0F → 1/2/3 (background);
  - game sprite 12'h0A5 → 0/A/5;
  - end sprite enabled with 12'hFFF → still 0/A/5 (a=0).
- Fade: FADE_STEP_FRAMES=1, game_over=1, end 12'hFFF over BG 12'h000 → R at a=1 is 0, at a=8 is 7, and reaches SHOW with F after 16 ticks, then holds.
- Abort: game_over deasserted in the same cycle as a tick, at a=9 → next cycle a=0, IDLE, and the under layer is shown immediately.
- Blanking: video_on=0 with both sprites enabled → RGB 0, and sync still passes with 2-cycle latency.

Source files
------------

// File: rtl/compositor_pkg.sv
// Shared types and widths for the pixel compositor.
package compositor_pkg;

  localparam int unsigned CHAN_W    = 4;
  localparam int unsigned COLOR_W   = 12;
  localparam int unsigned ALPHA_W   = 5;
  localparam int unsigned ALPHA_MAX = 16;
  localparam int unsigned X_W       = 10;
  localparam int unsigned Y_W       = 9;
  localparam int unsigned FCNT_W    = 8;

  // Fade sequencing for the end screen.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FADE = 2'd1,
    SHOW = 2'd2
  } fade_state_t;

  // One pixel split into its {R,G,B} channels.
  typedef struct packed {
    logic [CHAN_W-1:0] r;
    logic [CHAN_W-1:0] g;
    logic [CHAN_W-1:0] b;
  } rgb_t;

  // Reinterpret a packed 12-bit colour as channels.
  function automatic rgb_t to_rgb(input logic [COLOR_W-1:0] c);
    return rgb_t'(c);
  endfunction

endpackage

// File: rtl/alpha_blend4.sv
// Single-channel blend: (e*a + u*(16-a)) >> 4, truncated.
module alpha_blend4
  import compositor_pkg::*;
(
  input  logic [CHAN_W-1:0]  e,
  input  logic [CHAN_W-1:0]  u,
  input  logic [ALPHA_W-1:0] a,
  output logic [CHAN_W-1:0]  blended_c
);

  localparam logic [ALPHA_W-1:0] A_FULL = ALPHA_W'(ALPHA_MAX);

  logic [7:0] e_term_c;
  logic [7:0] u_term_c;
  logic [7:0] sum_c;

  // Weighted sum fits in 8 bits (max 15*16 = 240), so no overflow.
  always_comb begin
    e_term_c  = 8'(e) * 8'(a);
    u_term_c  = 8'(u) * 8'(A_FULL - a);
    sum_c     = e_term_c + u_term_c;
    blended_c = CHAN_W'(sum_c >> 4);
  end

endmodule

// File: rtl/pixel_compositor.sv
// Final pixel stage: layer priority, colour key, end-screen fade, sync alignment.
module pixel_compositor
  import compositor_pkg::*;
#(
  parameter logic [COLOR_W-1:0] BG_COLOR         = 12'h000,
  parameter logic [COLOR_W-1:0] KEY_COLOR        = 12'hF0F,
  parameter int unsigned        FADE_STEP_FRAMES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [X_W-1:0]     x,
  input  logic [Y_W-1:0]     y,
  input  logic               video_on,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic [COLOR_W-1:0] game_sprite_data,
  input  logic               game_sprite_enable,
  input  logic [COLOR_W-1:0] end_sprite_data_out,
  input  logic               end_sprite_enable,
  input  logic               game_over,
  output logic [CHAN_W-1:0]  vga_r,
  output logic [CHAN_W-1:0]  vga_g,
  output logic [CHAN_W-1:0]  vga_b,
  output logic               hsync,
  output logic               vsync
);

  localparam logic [FCNT_W-1:0]  STEP_LAST  = FCNT_W'(FADE_STEP_FRAMES - 1);
  localparam logic [ALPHA_W-1:0] ALPHA_FULL = ALPHA_W'(ALPHA_MAX);
  localparam logic [ALPHA_W-1:0] ALPHA_LAST = ALPHA_W'(ALPHA_MAX - 1);

  // Stage-1 aligned timing
  logic video_on_d;
  logic hsync_d;
  logic vsync_d;

  // Frame tick
  logic origin_prev;
  logic origin_c;
  logic tick_c;

  // Fade state
  fade_state_t        state;
  logic [ALPHA_W-1:0] alpha;
  logic [FCNT_W-1:0]  frame_cnt;

  // Stage-1 pixel path
  rgb_t              under_c;
  rgb_t              end_px_c;
  rgb_t              pix_c;
  logic              end_visible_c;
  logic [CHAN_W-1:0] blend_r_c;
  logic [CHAN_W-1:0] blend_g_c;
  logic [CHAN_W-1:0] blend_b_c;

  // Delay stage-0 timing by one cycle to meet the sprite renderers' outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      video_on_d <= 1'b0;
      hsync_d    <= 1'b1;
      vsync_d    <= 1'b1;
    end else begin
      video_on_d <= video_on;
      hsync_d    <= hsync_in;
      vsync_d    <= vsync_in;
    end
  end

  // Tick fires on the first cycle of a run at the raster origin.
  always_comb begin
    origin_c = (x == '0) && (y == '0);
    tick_c   = origin_c && !origin_prev;
  end

  // Remember whether the previous raster position was the origin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      origin_prev <= 1'b0;
    end else begin
      origin_prev <= origin_c;
    end
  end

  // Fade sequencer: advances on frame ticks; game_over low clears at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      alpha     <= '0;
      frame_cnt <= '0;
    end else if (!game_over) begin
      state     <= IDLE;
      alpha     <= '0;
      frame_cnt <= '0;
    end else if (tick_c) begin
      case (state)
        IDLE: begin
          state     <= FADE;
          alpha     <= '0;
          frame_cnt <= '0;
        end
        FADE: begin
          if (frame_cnt == STEP_LAST) begin
            frame_cnt <= '0;
            alpha     <= alpha + ALPHA_W'(1);
            if (alpha == ALPHA_LAST) begin
              state <= SHOW;
            end
          end else begin
            frame_cnt <= frame_cnt + FCNT_W'(1);
          end
        end
        SHOW: begin
          alpha     <= ALPHA_FULL;
          frame_cnt <= '0;
        end
        default: begin
          state     <= IDLE;
          alpha     <= '0;
          frame_cnt <= '0;
        end
      endcase
    end
  end

  // Resolve the under layer and end-layer visibility (colour key applies to both).
  always_comb begin
    end_px_c = to_rgb(end_sprite_data_out);
    if (game_sprite_enable && (game_sprite_data != KEY_COLOR)) begin
      under_c = to_rgb(game_sprite_data);
    end else begin
      under_c = to_rgb(BG_COLOR);
    end
    end_visible_c = end_sprite_enable && (end_sprite_data_out != KEY_COLOR) &&
                    (alpha != '0);
  end

  alpha_blend4 u_blend_r (
    .e         (end_px_c.r),
    .u         (under_c.r),
    .a         (alpha),
    .blended_c (blend_r_c)
  );

  alpha_blend4 u_blend_g (
    .e         (end_px_c.g),
    .u         (under_c.g),
    .a         (alpha),
    .blended_c (blend_g_c)
  );

  alpha_blend4 u_blend_b (
    .e         (end_px_c.b),
    .u         (under_c.b),
    .a         (alpha),
    .blended_c (blend_b_c)
  );

  // Pick blanked, blended or plain under-layer pixel.
  always_comb begin
    if (!video_on_d) begin
      pix_c = '0;
    end else if (end_visible_c) begin
      pix_c.r = blend_r_c;
      pix_c.g = blend_g_c;
      pix_c.b = blend_b_c;
    end else begin
      pix_c = under_c;
    end
  end

  // Output register: RGB and syncs leave together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      vga_r <= pix_c.r;
      vga_g <= pix_c.g;
      vga_b <= pix_c.b;
      hsync <= hsync_d;
      vsync <= vsync_d;
    end
  end

endmodule

// File: tb/tb_pixel_compositor.sv
// Scoreboard bench for pixel_compositor (BG=123, KEY=F0F, one frame per alpha step).
module tb_pixel_compositor;

  logic        clk;
  logic        rst_n;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        video_on;
  logic        hsync_in;
  logic        vsync_in;
  logic [11:0] game_sprite_data;
  logic        game_sprite_enable;
  logic [11:0] end_sprite_data_out;
  logic        end_sprite_enable;
  logic        game_over;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        hsync;
  logic        vsync;

  pixel_compositor #(
    .BG_COLOR         (12'h123),
    .KEY_COLOR        (12'hF0F),
    .FADE_STEP_FRAMES (1)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .x                   (x),
    .y                   (y),
    .video_on            (video_on),
    .hsync_in            (hsync_in),
    .vsync_in            (vsync_in),
    .game_sprite_data    (game_sprite_data),
    .game_sprite_enable  (game_sprite_enable),
    .end_sprite_data_out (end_sprite_data_out),
    .end_sprite_enable   (end_sprite_enable),
    .game_over           (game_over),
    .vga_r               (vga_r),
    .vga_g               (vga_g),
    .vga_b               (vga_b),
    .hsync               (hsync),
    .vsync               (vsync)
  );

  typedef struct {
    int          due;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Sprite values for the pixel currently in stage 0; presented one cycle later.
  logic        pend_ge;
  logic [11:0] pend_gd;
  logic        pend_ee;
  logic [11:0] pend_ed;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Expected blend from the channel formula (a in 0..16).
  function automatic logic [11:0] mix(input logic [11:0] e, input logic [11:0] u, input int a);
    logic [11:0] r;
    int ec;
    int uc;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      ec = int'(e[4*i +: 4]);
      uc = int'(u[4*i +: 4]);
      r[4*i +: 4] = 4'((ec * a + uc * (16 - a)) / 16);
    end
    return r;
  endfunction

  // Monitor: compare the output slot each expectation was scheduled for.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        e = sb.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL %s: slot %0d passed without a check (now %0d)", e.nm, e.due, cyc);
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        n_cmp++;
        if ({vga_r, vga_g, vga_b} !== e.rgb || hsync !== e.hs || vsync !== e.vs) begin
          n_bad++;
          $display("FAIL %s: got rgb=%h hs=%b vs=%b, expected rgb=%h hs=%b vs=%b",
                   e.nm, {vga_r, vga_g, vga_b}, hsync, vsync, e.rgb, e.hs, e.vs);
        end
      end
    end
  end

  // Present one raster position; expectation is due two cycles later.
  task automatic px(input int px_x, input int px_y, input logic von, input logic hs,
                    input logic vs, input logic ge, input logic [11:0] gd, input logic ee,
                    input logic [11:0] ed, input logic go, input logic [11:0] exp_rgb,
                    input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    x                   = 10'(px_x);
    y                   = 9'(px_y);
    video_on            = von;
    hsync_in            = hs;
    vsync_in            = vs;
    game_over           = go;
    game_sprite_enable  = pend_ge;
    game_sprite_data    = pend_gd;
    end_sprite_enable   = pend_ee;
    end_sprite_data_out = pend_ed;
    pend_ge = ge;
    pend_gd = gd;
    pend_ee = ee;
    pend_ed = ed;
    e.due = cyc + 2;
    e.rgb = exp_rgb;
    e.hs  = hs;
    e.vs  = vs;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  // One two-pixel frame: origin then (1,0), both at the same alpha.
  task automatic frame(input logic [11:0] gd, input logic [11:0] ed, input logic go,
                       input logic s, input logic [11:0] exp_rgb, input string nm);
    px(0, 0, 1'b1, s, s, 1'b1, gd, 1'b1, ed, go, exp_rgb, nm);
    px(1, 0, 1'b1, s, s, 1'b1, gd, 1'b1, ed, go, exp_rgb, nm);
  endtask

  task automatic chk_reset(input string nm);
    n_cmp++;
    if ({vga_r, vga_g, vga_b} !== 12'h000 || hsync !== 1'b1 || vsync !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: got rgb=%h hs=%b vs=%b, expected rgb=000 hs=1 vs=1",
               nm, {vga_r, vga_g, vga_b}, hsync, vsync);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    x = 10'd1; y = 9'd1; video_on = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    game_sprite_data = 12'h000; game_sprite_enable = 1'b0;
    end_sprite_data_out = 12'h000; end_sprite_enable = 1'b0; game_over = 1'b0;
    pend_ge = 1'b0; pend_gd = 12'h000; pend_ee = 1'b0; pend_ed = 12'h000;

    #7 chk_reset("reset_init");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Latency: background with a one-cycle hsync pulse.
    px(1, 5, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 12'h123, "lat_pre");
    px(2, 5, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 12'h123, "lat_hs_low");
    px(3, 5, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 12'h123, "lat_post");

    // Key and priority with game_over low.
    px(4, 5, 1'b1, 1'b1, 1'b1, 1'b1, 12'hF0F, 1'b0, 12'h000, 1'b0, 12'h123, "key_game");
    px(5, 5, 1'b1, 1'b1, 1'b1, 1'b1, 12'h0A5, 1'b0, 12'h000, 1'b0, 12'h0A5, "game_px");
    px(6, 5, 1'b1, 1'b1, 1'b1, 1'b1, 12'h0A5, 1'b1, 12'hFFF, 1'b0, 12'h0A5, "end_a0");
    px(7, 5, 1'b1, 1'b1, 1'b1, 1'b0, 12'h0A5, 1'b0, 12'h000, 1'b0, 12'h123, "game_dis");
    px(8, 5, 1'b1, 1'b1, 1'b1, 1'b1, 12'hF0F, 1'b1, 12'hF0F, 1'b0, 12'h123, "both_key");

    // Full fade of white over black, then hold.
    px(9, 5, 1'b1, 1'b1, 1'b1, 1'b1, 12'h000, 1'b1, 12'hFFF, 1'b1, 12'h000, "fade_pre");
    for (int j = 0; j <= 18; j++) begin
      frame(12'h000, 12'hFFF, 1'b1, 1'b1, mix(12'hFFF, 12'h000, (j > 16) ? 16 : j), "fade");
    end
    px(2, 0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h0A5, 1'b1, 12'hF0F, 1'b1, 12'h0A5, "show_key");
    px(3, 0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h0A5, 1'b0, 12'hFFF, 1'b1, 12'h0A5, "show_dis");

    // Mid-frame clear, refade to a=9, abort on a tick.
    px(4, 0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h0A5, 1'b1, 12'hFFF, 1'b0, 12'h0A5, "clear_mid");
    px(5, 0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h0A5, 1'b1, 12'hFFF, 1'b1, 12'h0A5, "idle_go");
    for (int j = 0; j <= 9; j++) begin
      frame(12'h0A5, 12'hFFF, 1'b1, 1'b1, mix(12'hFFF, 12'h0A5, j), "refade");
    end
    px(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h0A5, 1'b1, 12'hFFF, 1'b0, 12'h0A5, "abort_tick");
    px(1, 0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h0A5, 1'b1, 12'hFFF, 1'b0, 12'h0A5, "abort_idle");
    px(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h0A5, 1'b1, 12'hFFF, 1'b0, 12'h0A5, "abort_tick2");

    // Staying at the origin does not re-tick.
    px(1, 0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h0A5, 1'b1, 12'hFFF, 1'b1, 12'h0A5, "hist_pre");
    for (int k = 0; k < 4; k++) begin
      px(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h0A5, 1'b1, 12'hFFF, 1'b1, 12'h0A5, "hist_hold");
    end
    for (int k = 1; k <= 3; k++) begin
      px(1, 0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h0A5, 1'b1, 12'hFFF, 1'b1,
         mix(12'hFFF, 12'h0A5, k - 1), "hist_px");
      px(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h0A5, 1'b1, 12'hFFF, 1'b1,
         mix(12'hFFF, 12'h0A5, k), "hist_tick");
    end

    // Blanking: RGB forced to 0, vsync still aligned.
    px(5, 7, 1'b0, 1'b1, 1'b1, 1'b1, 12'h0A5, 1'b1, 12'hFFF, 1'b0, 12'h000, "blank");
    px(6, 7, 1'b0, 1'b1, 1'b0, 1'b1, 12'h0A5, 1'b1, 12'hFFF, 1'b0, 12'h000, "blank_vs");
    px(7, 7, 1'b0, 1'b1, 1'b1, 1'b1, 12'h0A5, 1'b1, 12'hFFF, 1'b0, 12'h000, "blank_post");
    px(8, 7, 1'b1, 1'b1, 1'b1, 1'b1, 12'h0A5, 1'b1, 12'hFFF, 1'b0, 12'h0A5, "unblank");

    // Mid-fade reset with syncs low.
    px(9, 7, 1'b1, 1'b1, 1'b1, 1'b1, 12'h000, 1'b1, 12'hFFF, 1'b1, 12'h000, "rst_pre");
    for (int j = 0; j <= 4; j++) begin
      frame(12'h000, 12'hFFF, 1'b1, (j == 4) ? 1'b0 : 1'b1, mix(12'hFFF, 12'h000, j), "rst_fade");
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_reset("reset_async");
    sb.delete();
    x = 10'd0; y = 9'd0; video_on = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1; game_over = 1'b1;
    pend_ge = 1'b1; pend_gd = 12'h000; pend_ee = 1'b1; pend_ed = 12'hFFF;
    repeat (2) @(posedge clk);
    #1 chk_reset("reset_hold");
    #1 rst_n = 1'b1;

    // First edge after release sees the origin with no tick history: fade restarts at a=0.
    px(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h000, 1'b1, 12'hFFF, 1'b1, 12'h000, "post_a0");
    for (int j = 1; j <= 3; j++) begin
      px(1, 0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h000, 1'b1, 12'hFFF, 1'b1,
         mix(12'hFFF, 12'h000, j - 1), "post_px");
      px(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h000, 1'b1, 12'hFFF, 1'b1,
         mix(12'hFFF, 12'h000, j), "post_tick");
    end

    repeat (3) px(8, 8, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 12'h000, "flush");
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
